// File: rtl/i2c_temp_poller.sv
// i2c_temp_poller: transaction sequencer sitting in front of the byte-level I2C
// master. Periodically reads the 13-bit temperature from the on-board sensor
// (pointer write 0x00, repeated start, 2-byte read) and publishes it.
// Optional feature macro: TEMP_ALARM_EN (registered over-temperature alarm).
module i2c_temp_poller #(
  parameter logic [6:0]  DEV_ADDR       = 7'h4B,
  parameter int unsigned POWERUP_CYCLES = 100_000_000,
  parameter int unsigned POLL_CYCLES    = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [12:0] ALARM_LEVEL    = 13'h0320
) (
  input  logic        CLK,
  input  logic        SRST,
  input  logic        I2C_DONE_I,
  input  logic        I2C_ERR_I,
  input  logic [7:0]  I2C_D_I,
  output logic        I2C_STB_O,
  output logic        I2C_MSG_O,
  output logic [7:0]  I2C_A_O,
  output logic [7:0]  I2C_D_O,
  output logic [12:0] TEMP_O,
  output logic        TEMP_VLD_O,
  output logic        ERR_O,
  output logic        BUSY_O,
  output logic        ALARM_O
);

  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > POLL_CYCLES) ? POWERUP_CYCLES : POLL_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PWRUP_LOAD = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LOAD  = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_PTR,
    ST_RD_MSB,
    ST_RD_LSB,
    ST_PUBLISH,
    ST_FAIL,
    ST_WAIT
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;      // wait counter in PWRUP/WAIT, watchdog in transaction states
  logic [7:0]     msb;
  logic [4:0]     lsb_hi;

`ifndef TEMP_ALARM_EN
  logic unused_alarm_level;
  assign unused_alarm_level = ^ALARM_LEVEL;
  assign ALARM_O = 1'b0;
`endif

  // Poll sequencer: single registered FSM driving every output.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state      <= ST_PWRUP;
      cnt        <= PWRUP_LOAD;
      msb        <= '0;
      lsb_hi     <= '0;
      I2C_STB_O  <= 1'b0;
      I2C_MSG_O  <= 1'b0;
      I2C_A_O    <= '0;
      I2C_D_O    <= '0;
      TEMP_O     <= '0;
      TEMP_VLD_O <= 1'b0;
      ERR_O      <= 1'b0;
      BUSY_O     <= 1'b0;
`ifdef TEMP_ALARM_EN
      ALARM_O    <= 1'b0;
`endif
    end else begin
      TEMP_VLD_O <= 1'b0;
      case (state)
        // Power-up and inter-poll waits share the same entry into ST_PTR.
        ST_PWRUP, ST_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_PTR;
            cnt       <= TO_LOAD;
            I2C_STB_O <= 1'b1;
            I2C_MSG_O <= 1'b1;
            I2C_A_O   <= {DEV_ADDR, 1'b0};
            I2C_D_O   <= 8'h00;
            BUSY_O    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PTR: begin
          if (I2C_DONE_I) begin
            cnt       <= TO_LOAD;
            I2C_MSG_O <= 1'b0;
            if (I2C_ERR_I) begin
              state     <= ST_FAIL;
              I2C_STB_O <= 1'b0;
            end else begin
              state   <= ST_RD_MSB;
              I2C_A_O <= {DEV_ADDR, 1'b1};
            end
          end else if (cnt == '0) begin
            state     <= ST_FAIL;
            I2C_STB_O <= 1'b0;
            I2C_MSG_O <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RD_MSB: begin
          if (I2C_DONE_I) begin
            cnt       <= TO_LOAD;
            I2C_STB_O <= 1'b0;
            if (I2C_ERR_I) begin
              state <= ST_FAIL;
            end else begin
              state <= ST_RD_LSB;
              msb   <= I2C_D_I;
            end
          end else if (cnt == '0) begin
            state     <= ST_FAIL;
            I2C_STB_O <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Master NACKs the final byte itself, so ERR is not meaningful here.
        ST_RD_LSB: begin
          if (I2C_DONE_I) begin
            cnt    <= TO_LOAD;
            state  <= ST_PUBLISH;
            lsb_hi <= I2C_D_I[7:3];
          end else if (cnt == '0) begin
            state <= ST_FAIL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PUBLISH: begin
          state      <= ST_WAIT;
          cnt        <= POLL_LOAD;
          TEMP_O     <= {msb, lsb_hi};
          TEMP_VLD_O <= 1'b1;
          ERR_O      <= 1'b0;
          BUSY_O     <= 1'b0;
`ifdef TEMP_ALARM_EN
          ALARM_O    <= ($signed({msb, lsb_hi}) >= $signed(ALARM_LEVEL));
`endif
        end
        ST_FAIL: begin
          state     <= ST_WAIT;
          cnt       <= POLL_LOAD;
          I2C_STB_O <= 1'b0;
          I2C_MSG_O <= 1'b0;
          ERR_O     <= 1'b1;
          BUSY_O    <= 1'b0;
        end
        default: begin
          state <= ST_PWRUP;
          cnt   <= PWRUP_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_poller.sv
// Self-checking bench for i2c_temp_poller with a behavioural I2C master that
// answers every request 10 cycles later, plus a temperature/alarm model.
module tb_i2c_temp_poller;

  logic        CLK = 1'b0;
  logic        SRST = 1'b1;
  logic        I2C_DONE_I = 1'b0;
  logic        I2C_ERR_I = 1'b0;
  logic [7:0]  I2C_D_I = 8'h00;
  logic        I2C_STB_O, I2C_MSG_O, TEMP_VLD_O, ERR_O, BUSY_O, ALARM_O;
  logic [7:0]  I2C_A_O, I2C_D_O;
  logic [12:0] TEMP_O;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [12:0] exp_temp = '0;
  logic        exp_err = 1'b0;
  logic        exp_alarm = 1'b0;

  i2c_temp_poller #(
    .DEV_ADDR       (7'h4B),
    .POWERUP_CYCLES (20),
    .POLL_CYCLES    (50),
    .TIMEOUT_CYCLES (30),
    .ALARM_LEVEL    (13'h0320)
  ) dut (
    .CLK        (CLK),
    .SRST       (SRST),
    .I2C_DONE_I (I2C_DONE_I),
    .I2C_ERR_I  (I2C_ERR_I),
    .I2C_D_I    (I2C_D_I),
    .I2C_STB_O  (I2C_STB_O),
    .I2C_MSG_O  (I2C_MSG_O),
    .I2C_A_O    (I2C_A_O),
    .I2C_D_O    (I2C_D_O),
    .TEMP_O     (TEMP_O),
    .TEMP_VLD_O (TEMP_VLD_O),
    .ERR_O      (ERR_O),
    .BUSY_O     (BUSY_O),
    .ALARM_O    (ALARM_O)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic cyc;
    @(negedge CLK);
  endtask

  // Reference: temperature word is MSB followed by the top five LSB bits,
  // read as a 13-bit two's complement value in 1/16 C.
  task automatic model_publish(input logic [7:0] msb, input logic [7:0] lsb);
    int raw, sval;
    raw = msb * 32 + lsb / 8;
    sval = (raw >= 4096) ? raw - 8192 : raw;
    exp_temp = 13'(raw);
    exp_err = 1'b0;
`ifdef TEMP_ALARM_EN
    exp_alarm = (sval >= 800);
`else
    exp_alarm = (sval < -9999);
`endif
  endtask

  // Waits for the next request (STB high), optionally injecting a stray DONE.
  task automatic wait_stb(input int stray_at, output int n, output int vlds);
    n = 0;
    vlds = 0;
    while (n < 200 && I2C_STB_O !== 1'b1) begin
      I2C_DONE_I = (n == stray_at);
      I2C_ERR_I  = 1'($urandom);
      I2C_D_I    = 8'($urandom);
      cyc;
      n++;
      if (TEMP_VLD_O === 1'b1) vlds++;
    end
    I2C_DONE_I = 1'b0;
    I2C_ERR_I  = 1'b0;
  endtask

  // fault: 0 good, 1 pointer NACK, 2 no DONE in MSB read, 3 MSB address NACK.
  // Entered with the pointer request just observed; leaves at the next request.
  task automatic run_poll(input logic [7:0] msb, input logic [7:0] lsb, input int fault, input string tag);
    int n, drops, vlds;
    vectors++;
    if (I2C_A_O !== 8'h96 || I2C_MSG_O !== 1'b1 || I2C_D_O !== 8'h00 || BUSY_O !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ptr_req: got A=%h MSG=%b D=%h BUSY=%b, expected A=96 MSG=1 D=00 BUSY=1",
               tag, I2C_A_O, I2C_MSG_O, I2C_D_O, BUSY_O);
    end
    drops = 0;
    repeat (9) begin cyc; if (I2C_STB_O !== 1'b1) drops++; end
    vectors++;
    if (drops != 0) begin
      miscompares++;
      $display("FAIL %s ptr_stb_hold: got %0d low cycles, expected 0", tag, drops);
    end
    I2C_DONE_I = 1'b1; I2C_ERR_I = (fault == 1); I2C_D_I = 8'($urandom);
    cyc;
    I2C_DONE_I = 1'b0; I2C_ERR_I = 1'b0;
    if (fault == 1) begin
      vectors++;
      if (I2C_STB_O !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ptr_nack_stb: got STB=%b, expected 0", tag, I2C_STB_O);
      end
      cyc;
      exp_err = 1'b1;
    end else begin
      vectors++;
      if (I2C_A_O !== 8'h97 || I2C_STB_O !== 1'b1 || I2C_MSG_O !== 1'b0) begin
        miscompares++;
        $display("FAIL %s rd_req: got A=%h STB=%b MSG=%b, expected A=97 STB=1 MSG=0",
                 tag, I2C_A_O, I2C_STB_O, I2C_MSG_O);
      end
      if (fault == 2) begin
        n = 0;
        while (n < 100 && I2C_STB_O === 1'b1) begin cyc; n++; end
        vectors++;
        if (n != 30) begin
          miscompares++;
          $display("FAIL %s watchdog: got %0d cycles, expected 30", tag, n);
        end
        cyc;
        exp_err = 1'b1;
      end else begin
        drops = 0;
        repeat (9) begin cyc; if (I2C_STB_O !== 1'b1) drops++; end
        vectors++;
        if (drops != 0) begin
          miscompares++;
          $display("FAIL %s msb_stb_hold: got %0d low cycles, expected 0", tag, drops);
        end
        I2C_DONE_I = 1'b1; I2C_ERR_I = (fault == 3); I2C_D_I = msb;
        cyc;
        I2C_DONE_I = 1'b0; I2C_ERR_I = 1'b0;
        if (fault == 3) begin
          vectors++;
          if (I2C_STB_O !== 1'b0) begin
            miscompares++;
            $display("FAIL %s msb_nack_stb: got STB=%b, expected 0", tag, I2C_STB_O);
          end
          cyc;
          exp_err = 1'b1;
        end else begin
          vectors++;
          if (I2C_STB_O !== 1'b0 || I2C_MSG_O !== 1'b0 || BUSY_O !== 1'b1) begin
            miscompares++;
            $display("FAIL %s lsb_phase: got STB=%b MSG=%b BUSY=%b, expected STB=0 MSG=0 BUSY=1",
                     tag, I2C_STB_O, I2C_MSG_O, BUSY_O);
          end
          repeat (9) cyc;
          I2C_DONE_I = 1'b1; I2C_D_I = lsb;
          cyc;
          I2C_DONE_I = 1'b0;
          cyc;
          model_publish(msb, lsb);
          vectors++;
          if (TEMP_VLD_O !== 1'b1) begin
            miscompares++;
            $display("FAIL %s vld_pulse: got %b, expected 1", tag, TEMP_VLD_O);
          end
        end
      end
    end
    // End-of-poll status, observed the cycle after PUBLISH/FAIL.
    vectors++;
    if (TEMP_O !== exp_temp || ERR_O !== exp_err || BUSY_O !== 1'b0 || ALARM_O !== exp_alarm) begin
      miscompares++;
      $display("FAIL %s result: got TEMP=%h ERR=%b BUSY=%b ALARM=%b, expected TEMP=%h ERR=%b BUSY=0 ALARM=%b",
               tag, TEMP_O, ERR_O, BUSY_O, ALARM_O, exp_temp, exp_err, exp_alarm);
    end
    wait_stb(20, n, vlds);
    vectors++;
    if (n != 50 || vlds != 0) begin
      miscompares++;
      $display("FAIL %s poll_interval: got %0d cycles, %0d extra VLD; expected 50 cycles, 0 VLD", tag, n, vlds);
    end
    vectors++;
    if (TEMP_O !== exp_temp || ERR_O !== exp_err || ALARM_O !== exp_alarm) begin
      miscompares++;
      $display("FAIL %s held: got TEMP=%h ERR=%b ALARM=%b, expected TEMP=%h ERR=%b ALARM=%b",
               tag, TEMP_O, ERR_O, ALARM_O, exp_temp, exp_err, exp_alarm);
    end
  endtask

  task automatic test_reset;
    int n, vlds;
    SRST = 1'b1;
    repeat (3) cyc;
    vectors++;
    if ({I2C_STB_O, I2C_MSG_O, I2C_A_O, I2C_D_O, TEMP_O, TEMP_VLD_O, ERR_O, BUSY_O, ALARM_O} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got STB=%b MSG=%b A=%h D=%h TEMP=%h VLD=%b ERR=%b BUSY=%b ALARM=%b, expected all 0",
               I2C_STB_O, I2C_MSG_O, I2C_A_O, I2C_D_O, TEMP_O, TEMP_VLD_O, ERR_O, BUSY_O, ALARM_O);
    end
    SRST = 1'b0;
    wait_stb(-1, n, vlds);
    vectors++;
    if (n != 20) begin
      miscompares++;
      $display("FAIL powerup_wait: got %0d cycles, expected 20", n);
    end
  endtask

  task automatic test_good_poll;
    run_poll(8'h19, 8'h80, 0, "good");
  endtask

  task automatic test_ptr_nack;
    run_poll(8'h00, 8'h00, 1, "ptr_nack");
  endtask

  task automatic test_timeout;
    run_poll(8'h00, 8'h00, 2, "timeout");
    run_poll(8'($urandom), 8'($urandom), 0, "recover");
  endtask

  task automatic test_msb_nack;
    run_poll(8'h00, 8'h00, 3, "msb_nack");
  endtask

  task automatic test_negative;
    run_poll(8'hE7, 8'h00, 0, "negative");
  endtask

  task automatic test_alarm;
    run_poll(8'h19, 8'h00, 0, "alarm_at_level");
    run_poll(8'h18, 8'hF8, 0, "alarm_below");
  endtask

  task automatic test_back_to_back;
    int sel, fault;
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 5));
      fault = (sel <= 2) ? 0 : sel - 2;
      run_poll(8'($urandom), 8'($urandom), fault, "random");
    end
  endtask

  task automatic test_srst_mid;
    int n, vlds;
    repeat (9) cyc;
    I2C_DONE_I = 1'b1; I2C_ERR_I = 1'b0;
    cyc;
    I2C_DONE_I = 1'b0;
    vectors++;
    if (I2C_A_O !== 8'h97 || I2C_STB_O !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_pre: got A=%h STB=%b, expected A=97 STB=1", I2C_A_O, I2C_STB_O);
    end
    repeat (3) cyc;
    SRST = 1'b1;
    cyc;
    SRST = 1'b0;
    exp_temp = '0; exp_err = 1'b0; exp_alarm = 1'b0;
    vectors++;
    if ({I2C_STB_O, I2C_MSG_O, I2C_A_O, I2C_D_O, TEMP_O, TEMP_VLD_O, ERR_O, BUSY_O, ALARM_O} !== '0) begin
      miscompares++;
      $display("FAIL srst_outputs: got STB=%b MSG=%b A=%h D=%h TEMP=%h VLD=%b ERR=%b BUSY=%b ALARM=%b, expected all 0",
               I2C_STB_O, I2C_MSG_O, I2C_A_O, I2C_D_O, TEMP_O, TEMP_VLD_O, ERR_O, BUSY_O, ALARM_O);
    end
    wait_stb(-1, n, vlds);
    vectors++;
    if (n != 20) begin
      miscompares++;
      $display("FAIL srst_powerup: got %0d cycles, expected 20", n);
    end
    run_poll(8'($urandom), 8'($urandom), 0, "after_srst");
  endtask

  initial begin
    test_reset;
    test_good_poll;
    test_ptr_nack;
    test_timeout;
    test_negative;
    test_alarm;
    test_msb_nack;
    test_good_poll;
    test_back_to_back;
    test_srst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
